// File: rtl/scalar_multiply_mat_seq.sv
// Scales a SIZE_A x SIZE_B double matrix by a scalar through one shared,
// fully pipelined double-precision multiplier, one element per cycle.

module fp_mult #(
   parameter int LATENCY = 11
) (
   input  logic        clk,
   input  logic        aclr,
   input  logic        clk_en,
   input  logic [63:0] dataa,
   input  logic [63:0] datab,
   output logic [63:0] result,
   output logic        overflow,
   output logic        nan
);
   typedef struct packed {
      logic        nan;
      logic        ov;
      logic [63:0] res;
   } fpm_t;

   // Round-to-nearest-even; subnormal operands and results flush to signed zero.
   function automatic fpm_t fmul(input logic [63:0] a, input logic [63:0] b);
      fpm_t               r;
      logic               s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
      logic [105:0]       p;
      logic [52:0]        m;
      logic [53:0]        mr;
      logic signed [13:0] e;
      r      = '0;
      s      = a[63] ^ b[63];
      a_nan  = (a[62:52] == 11'h7ff) && (a[51:0] != '0);
      b_nan  = (b[62:52] == 11'h7ff) && (b[51:0] != '0);
      a_inf  = (a[62:52] == 11'h7ff) && (a[51:0] == '0);
      b_inf  = (b[62:52] == 11'h7ff) && (b[51:0] == '0);
      a_zero = (a[62:52] == 11'h000);
      b_zero = (b[62:52] == 11'h000);
      p      = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
      e      = $signed({3'b0, a[62:52]}) + $signed({3'b0, b[62:52]}) - 14'sd1023;
      if (p[105]) begin
         m  = p[105:53];
         g  = p[52];
         st = |p[51:0];
         e  = e + 14'sd1;
      end else begin
         m  = p[104:52];
         g  = p[51];
         st = |p[50:0];
      end
      mr = {1'b0, m} + {53'b0, g & (st | m[0])};
      if (mr[53]) begin
         mr = mr >> 1;
         e  = e + 14'sd1;
      end
      if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
         r.res = 64'h7ff8000000000000;
         r.nan = 1'b1;
      end else if (a_inf || b_inf)
         r.res = {s, 11'h7ff, 52'b0};
      else if (a_zero || b_zero)
         r.res = {s, 63'b0};
      else if (e >= 14'sd2047) begin
         r.res = {s, 11'h7ff, 52'b0};
         r.ov  = 1'b1;
      end else if (e <= 14'sd0)
         r.res = {s, 63'b0};
      else
         r.res = {s, e[10:0], mr[51:0]};
      return r;
   endfunction

   fpm_t [LATENCY:1] pipe;

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) pipe <= '0;
      else if (clk_en) begin
         pipe[1] <= fmul(dataa, datab);
         for (int i = 2; i <= LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign result   = pipe[LATENCY].res;
   assign overflow = pipe[LATENCY].ov;
   assign nan      = pipe[LATENCY].nan;
endmodule

module scalar_multiply_mat_seq #(
   parameter int SIZE_A  = 8,
   parameter int SIZE_B  = 8,
   parameter int LATENCY = 11
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [63:0]                           scale,
   input  logic [SIZE_A-1:0][SIZE_B-1:0][63:0]   mat,
   output logic [SIZE_A-1:0][SIZE_B-1:0][63:0]   mat_out,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  overflow,
   output logic                                  nan
);
   localparam int N  = SIZE_A * SIZE_B;
   localparam int TW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]              state;
   // Flat views: packed [row][col] layout is already row-major, so index k maps directly.
   logic [N-1:0][63:0]      cp, res_q;
   logic [63:0]             scale_q;
   logic [TW-1:0]           k;
   logic [LATENCY:1]        vld_pipe;
   logic [LATENCY:1][TW-1:0] tag_pipe;
   logic                    last_wr, wb, last_tag;
   logic [63:0]             fm_res;
   logic                    fm_ov, fm_nan;

   assign wb       = vld_pipe[LATENCY];
   assign last_tag = wb && (tag_pipe[LATENCY] == TW'(N-1));
   assign done     = (state == DONE);
   assign mat_out  = res_q;

   fp_mult #(.LATENCY(LATENCY)) u_fpm (
      .clk      (clk),
      .aclr     (~rst),
      .clk_en   (state != IDLE),
      .dataa    (cp[k]),
      .datab    (scale_q),
      .result   (fm_res),
      .overflow (fm_ov),
      .nan      (fm_nan)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         tag_pipe <= '0;
      end else begin
         vld_pipe[1] <= (state == ISSUE);
         tag_pipe[1] <= k;
         for (int i = 2; i <= LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         overflow <= 1'b0;
         nan      <= 1'b0;
         res_q    <= '0;
         cp       <= '0;
         scale_q  <= '0;
         k        <= '0;
         last_wr  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cp       <= mat;
               scale_q  <= scale;
               overflow <= 1'b0;
               nan      <= 1'b0;
               k        <= '0;
               state    <= ISSUE;
            end
            ISSUE: begin
               busy <= 1'b1;
               if (k == TW'(N-1)) state <= DRAIN;
               else k <= k + TW'(1);
            end
            DRAIN: if (last_wr) begin
               busy  <= 1'b0;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
         if (wb) begin
            res_q[tag_pipe[LATENCY]] <= fm_res;
            overflow                 <= overflow | fm_ov;
            nan                      <= nan | fm_nan;
         end
         // The final write lands one edge before DONE so done follows the last update.
         last_wr <= last_tag;
      end
   end
endmodule

// File: tb/tb_scalar_multiply_mat_seq.sv
// Randomised and directed checks of scalar_multiply_mat_seq against a
// real-arithmetic reference model (2x2, LATENCY=11).

module tb_scalar_multiply_mat_seq;
   localparam int A = 2;
   localparam int B = 2;
   localparam int L = 11;
   localparam int N = A * B;

   logic                   clk, rst, start;
   logic [63:0]            scale;
   logic [A-1:0][B-1:0][63:0] mat, mat_out;
   logic                   busy, done, overflow, nan;

   int checks   = 0;
   int failures = 0;

   logic [63:0] stim   [N];
   logic [63:0] exp_m  [N];
   logic [63:0] prev_m [N];
   logic        exp_ov, exp_nan;

   scalar_multiply_mat_seq #(.SIZE_A(A), .SIZE_B(B), .LATENCY(L)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .scale    (scale),
      .mat      (mat),
      .mat_out  (mat_out),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .nan      (nan)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit is_nan(input logic [63:0] v);
      return (v[62:52] == 11'h7ff) && (v[51:0] != '0);
   endfunction

   function automatic bit is_inf(input logic [63:0] v);
      return (v[62:52] == 11'h7ff) && (v[51:0] == '0);
   endfunction

   function automatic bit held_prev();
      bit ok = 1'b1;
      for (int i = 0; i < N; i++) begin
         logic [63:0] g;
         g = mat_out[i/B][i%B];
         if (!((is_nan(g) && is_nan(prev_m[i])) || g === prev_m[i])) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [63:0] rnd_dbl(input int spread);
      logic [63:0] v;
      v = {$urandom, $urandom};
      v[62:52] = 11'(1023 - spread + int'($urandom_range(2 * spread)));
      return v;
   endfunction

   task automatic model(input logic [63:0] s);
      exp_ov  = 1'b0;
      exp_nan = 1'b0;
      for (int i = 0; i < N; i++) begin
         exp_m[i] = $realtobits($bitstoreal(stim[i]) * $bitstoreal(s));
         if (is_nan(exp_m[i])) exp_nan = 1'b1;
         if (is_inf(exp_m[i]) && !is_inf(stim[i]) && !is_inf(s)) exp_ov = 1'b1;
      end
   endtask

   // Runs one job; returns in the first idle cycle after done.
   task automatic run_job(input string name, input logic [63:0] s,
                          input bit junk_mid, input bit junk_done);
      int done_cyc = -1;
      int busy_cnt = 0;
      model(s);
      for (int i = 0; i < N; i++) mat[i/B][i%B] = stim[i];
      scale = s;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mat   = {N{$urandom, $urandom}};
      scale = {$urandom, $urandom};
      for (int j = 1; j <= N + L + 8 && done_cyc < 0; j++) begin
         @(posedge clk); #1;
         if (j == 1) chk({name, "_flags_clr"}, {62'b0, overflow, nan}, 64'd0);
         if (j == L) chk({name, "_hold"}, {63'b0, held_prev()}, 64'd1);
         if (busy) busy_cnt++;
         if (done) done_cyc = j;
         start = junk_mid && (j == 5);
      end
      start = junk_done;
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, "_done_cyc"}, 64'(done_cyc), 64'(N + L + 1));
      chk({name, "_busy_cnt"}, 64'(busy_cnt), 64'(N + L));
      chk({name, "_idle"}, {62'b0, busy, done}, 64'd0);
      for (int i = 0; i < N; i++) begin
         if (is_nan(exp_m[i])) chk({name, "_el_nan"}, {63'b0, is_nan(mat_out[i/B][i%B])}, 64'd1);
         else chk({name, "_el"}, mat_out[i/B][i%B], exp_m[i]);
      end
      chk({name, "_ov"}, {63'b0, overflow}, {63'b0, exp_ov});
      chk({name, "_nan"}, {63'b0, nan}, {63'b0, exp_nan});
      prev_m = exp_m;
   endtask

   initial begin
      rst   = 1'b0;
      start = 1'b0;
      scale = '0;
      mat   = '0;
      for (int i = 0; i < N; i++) prev_m[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {60'b0, busy, done, overflow, nan}, 64'd0);
      chk("rst_mat", {63'b0, held_prev()}, 64'd1);
      @(negedge clk) rst = 1'b1;

      // Directed: input scrambled after accept, start during busy and done ignored.
      stim = '{$realtobits(1.0), $realtobits(1.5), $realtobits(-2.0), $realtobits(0.25)};
      run_job("basic", 64'h4000000000000000, 1'b1, 1'b1);
      chk("basic_v3", mat_out[1][1], $realtobits(0.5));
      run_job("negate", $realtobits(-1.0), 1'b1, 1'b0);

      stim = '{$realtobits(1.0e308), $realtobits(1.0), $realtobits(2.5), $realtobits(-3.0)};
      run_job("ovf", $realtobits(10.0), 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 chk("ovf_sticky", {63'b0, overflow}, 64'd1);

      stim = '{64'h7ff8000000000000, $realtobits(1.0), $realtobits(-2.0), $realtobits(3.0)};
      run_job("nan", $realtobits(1.5), 1'b0, 1'b0);

      stim = '{$realtobits(4.0), $realtobits(-7.5), $realtobits(1.0e-3), $realtobits(-1.0)};
      run_job("zero", $realtobits(0.0), 1'b0, 1'b0);

      // Reset seven cycles into a job.
      stim = '{$realtobits(3.0), $realtobits(5.0), $realtobits(7.0), $realtobits(9.0)};
      for (int i = 0; i < N; i++) mat[i/B][i%B] = stim[i];
      scale = $realtobits(2.0);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_outs", {60'b0, busy, done, overflow, nan}, 64'd0);
      for (int i = 0; i < N; i++) prev_m[i] = '0;
      chk("mid_rst_mat", {63'b0, held_prev()}, 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      stim = '{$realtobits(-0.5), $realtobits(6.0), $realtobits(1.25), $realtobits(8.0)};
      run_job("post_rst", $realtobits(3.0), 1'b0, 1'b0);

      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < N; i++) stim[i] = rnd_dbl(100);
         run_job("rand", rnd_dbl(3), t[0], t[1]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
